hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 4, multiply/divide occupancy in cycles (legal 2..15).
REQ-002 Clock and reset: single clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  pipeline clock, rising-edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 id_op  in  6  opcode of instruction in ID (inst[31:26]).
REQ-006 id_funct  in  6  funct of instruction in ID (inst[5:0]).
REQ-007 id_rs, id_rt  in  5 each  source register fields in ID.
REQ-008 branch_equal  in  1  ID-stage register-file compare (RD1==RD2).
REQ-009 ex_memread  in  1  instruction in EX is a load.
REQ-010 ex_regwrite  in  1  instruction in EX writes a register.
REQ-011 ex_wr  in  5  destination register of instruction in EX.
REQ-012 pc_write  out  1  PC load enable.
REQ-013 ifid_write  out  1  IF/ID register load enable.
REQ-014 ifid_flush  out  1  zero IF/ID on next edge.
REQ-015 idex_bubble  out  1  insert NOP into ID/EX on next edge.
REQ-016 pc_src  out  1  select branch target for PC.
REQ-017 mdu_busy  out  1  multiply/divide unit occupied (mdu_cnt!=0).

Function
REQ-018 Decode: beq=op 0x04, bne=op 0x05; mult/div=op 0x00 with funct 0x18/0x1A; mfhi/mflo=op 0x00 with funct 0x10/0x12.
REQ-019 Stall = pc_write 0, ifid_write 0, idex_bubble 1, ifid_flush 0, pc_src 0; Normal = pc_write 1, ifid_write 1, others 0.
REQ-020 lu: ex_memread, ex_wr!=0, ex_wr equals id_rs or id_rt (both compared for every opcode).
REQ-021 br_dep: ID is beq/bne, ex_regwrite, ex_wr!=0, ex_wr equals id_rs or id_rt.
REQ-022 mdu_hz: mdu_cnt!=0 and ID holds mfhi/mflo or mult/div.
REQ-023 taken: beq with branch_equal=1, or bne with branch_equal=0.
REQ-024 FSM states RUN, HOLD, MDU_WAIT; combinational outputs from state plus inputs.
REQ-025 RUN priority: mdu_hz -> Stall, next MDU_WAIT; else br_dep and ex_memread -> Stall, next HOLD; else lu or br_dep -> Stall, stay RUN; else taken -> pc_write 1, pc_src 1, ifid_flush 1, ifid_write 1; else Normal.
REQ-026 HOLD: Stall for exactly one cycle unconditionally, next RUN; load-to-branch thus costs 2 stall cycles.
REQ-027 MDU_WAIT: Stall; transition to RUN when mdu_cnt==1, so ID resumes the cycle mdu_cnt reaches 0.
REQ-028 mdu_cnt (4 bits): loaded with MDU_LAT-1 on an edge where ID holds mult/div and the cycle is not a Stall; otherwise decrements when nonzero; never wraps below 0.
REQ-029 Branch flush and mdu_cnt load never coincide; a taken branch in ID does not touch mdu_cnt.

Reset
REQ-030 While rst=1: state RUN, mdu_cnt 0, pc_write 0, ifid_write 0, ifid_flush 1, idex_bubble 1, pc_src 0, mdu_busy 0.
REQ-031 Reset mid-stall (HOLD or MDU_WAIT) abandons the stall; first cycle after release evaluates from RUN.

Configuration
REQ-032 Macro HAZARD_PERF_EN defined: add outputs stall_cnt[15:0] (Stall cycles) and flush_cnt[15:0] (taken-branch flushes), both saturating at 0xFFFF, cleared by rst.
REQ-033 Macro HAZARD_PERF_EN undefined: those ports and counters do not exist; all other behaviour identical.

Structure
REQ-034 Shared package mips_pkg holds opcode/funct constants (OP_BEQ, OP_BNE, OP_RTYPE, FN_MULT, FN_DIV, FN_MFHI, FN_MFLO) and the hazard FSM state encoding.
REQ-035 Sub-module mdu_busy_counter implements mdu_cnt load/decrement and mdu_busy.

Verification
REQ-036 lw $8 in EX (ex_memread=1, ex_wr=8), ID add with id_rs=8 -> exactly 1 Stall cycle, then Normal.
REQ-037 lw $9 in EX, ID beq id_rt=9 -> 2 consecutive Stall cycles (RUN->HOLD->RUN), no flush.
REQ-038 ID beq rs=rt=3, no EX dependency, branch_equal=1 -> pc_src=1, ifid_flush=1 for one cycle; bne same operands -> Normal.
REQ-039 MDU_LAT=4: mult issues, next ID mflo -> mdu_busy high 3 cycles, mflo stalled 3 cycles, released when mdu_cnt=0.
REQ-040 ex_wr=0 with ex_memread=1, id_rs=0 -> no stall; rst pulsed during MDU_WAIT -> outputs at reset values, mdu_cnt=0, Normal after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and hazard-controller FSM encoding.
package mips_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PERF_W = 16;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;

  localparam logic [OP_W-1:0] FN_MFHI  = 6'h10;
  localparam logic [OP_W-1:0] FN_MFLO  = 6'h12;
  localparam logic [OP_W-1:0] FN_MULT  = 6'h18;
  localparam logic [OP_W-1:0] FN_DIV   = 6'h1A;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_e;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op, input logic [OP_W-1:0] funct);
    return (op == OP_RTYPE) && ((funct == FN_MULT) || (funct == FN_DIV));
  endfunction

  function automatic logic is_mfhilo(input logic [OP_W-1:0] op, input logic [OP_W-1:0] funct);
    return (op == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX hazard information in, pipeline control enables out.
interface hazard_ctrl_if;
  import mips_pkg::*;

  logic [OP_W-1:0]  id_op;
  logic [OP_W-1:0]  id_funct;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             branch_equal;
  logic             ex_memread;
  logic             ex_regwrite;
  logic [REG_W-1:0] ex_wr;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_bubble;
  logic pc_src;
  logic mdu_busy;

  modport master (
    output id_op, id_funct, id_rs, id_rt, branch_equal, ex_memread, ex_regwrite, ex_wr,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pc_src, mdu_busy
  );

  modport slave (
    input  id_op, id_funct, id_rs, id_rt, branch_equal, ex_memread, ex_regwrite, ex_wr,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pc_src, mdu_busy
  );
endinterface

// File: rtl/mdu_busy_counter.sv
// Multiply/divide occupancy counter: loads MDU_LAT-1 on issue, counts down to 0.
module mdu_busy_counter
  import mips_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_LAT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// MIPS ID-stage hazard controller: load-use, branch-dependency and MDU stalls, branch flush.
// Optional HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt event counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_if.slave      hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  hz_state_e        state;
  hz_state_e        state_nx;
  logic [CNT_W-1:0] mdu_cnt;
  logic             mdu_busy;
  logic             mdu_load;
  logic             stall;
  logic             flush;

  logic is_br;
  logic is_md;
  logic is_mf;
  logic reg_hit;
  logic lu;
  logic br_dep;
  logic taken;
  logic mdu_hz;

  assign is_br   = (hz.id_op == OP_BEQ) || (hz.id_op == OP_BNE);
  assign is_md   = is_muldiv(hz.id_op, hz.id_funct);
  assign is_mf   = is_mfhilo(hz.id_op, hz.id_funct);
  assign reg_hit = (hz.ex_wr != '0) && ((hz.ex_wr == hz.id_rs) || (hz.ex_wr == hz.id_rt));
  assign lu      = hz.ex_memread && reg_hit;
  assign br_dep  = is_br && hz.ex_regwrite && reg_hit;
  assign taken   = ((hz.id_op == OP_BEQ) && hz.branch_equal) ||
                   ((hz.id_op == OP_BNE) && !hz.branch_equal);
  assign mdu_hz  = mdu_busy && (is_md || is_mf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // MDU_WAIT is only entered with more than one busy cycle left, so it always exits on mdu_cnt==1.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    flush    = 1'b0;
    case (state)
      RUN: begin
        if (mdu_hz) begin
          stall = 1'b1;
          if (mdu_cnt > CNT_W'(1)) state_nx = MDU_WAIT;
        end else if (br_dep && hz.ex_memread) begin
          stall    = 1'b1;
          state_nx = HOLD;
        end else if (lu || br_dep) begin
          stall = 1'b1;
        end else if (taken) begin
          flush = 1'b1;
        end
      end
      HOLD: begin
        stall    = 1'b1;
        state_nx = RUN;
      end
      MDU_WAIT: begin
        stall = 1'b1;
        if (mdu_cnt <= CNT_W'(1)) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  assign mdu_load = is_md && !stall && !rst;

  mdu_busy_counter #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (mdu_load),
    .cnt  (mdu_cnt),
    .busy (mdu_busy)
  );

  // Reset forces a flushed, bubbled, frozen front end.
  assign hz.pc_write    = !rst && !stall;
  assign hz.ifid_write  = !rst && !stall;
  assign hz.ifid_flush  = rst || flush;
  assign hz.idex_bubble = rst || stall;
  assign hz.pc_src      = !rst && flush;
  assign hz.mdu_busy    = mdu_busy;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios, then randomized traffic against a model.
module tb_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] TAKEN = 6'b111010;
  localparam logic [5:0] RSTV  = 6'b001100;
  localparam logic [5:0] BUSY  = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: pending HOLD cycle, remaining MDU cycles, MDU lock carried over from a stalled cycle.
  bit m_hold = 0;
  bit m_lock = 0;
  int m_rem  = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  hazard_ctrl_if bus ();

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic be, input logic mr,
                       input logic rw, input logic [4:0] wr);
    bus.id_op = op;       bus.id_funct = fn;
    bus.id_rs = rs;       bus.id_rt = rt;
    bus.branch_equal = be;
    bus.ex_memread = mr;  bus.ex_regwrite = rw;
    bus.ex_wr = wr;
  endtask

  // Called just after a falling edge with inputs applied; checks, advances the model, waits one cycle.
  task automatic step(input string tag, input bit use_const, input logic [5:0] want);
    logic [5:0] obs;
    logic [5:0] exp;
    bit is_br, is_md, is_mf, hit, lu, bd, taken;
    bit e_stall, e_flush, mdu_stall, n_hold;
    #1;
    obs = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.pc_src, bus.mdu_busy};
    if (rst) begin
      exp = RSTV;
      m_hold = 0; m_lock = 0; m_rem = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      is_br = (bus.id_op == 6'h04) || (bus.id_op == 6'h05);
      is_md = (bus.id_op == 6'h00) && (bus.id_funct == 6'h18 || bus.id_funct == 6'h1A);
      is_mf = (bus.id_op == 6'h00) && (bus.id_funct == 6'h10 || bus.id_funct == 6'h12);
      hit   = (bus.ex_wr != 0) && (bus.ex_wr == bus.id_rs || bus.ex_wr == bus.id_rt);
      lu    = bus.ex_memread && hit;
      bd    = is_br && bus.ex_regwrite && hit;
      taken = (bus.id_op == 6'h04 && bus.branch_equal) || (bus.id_op == 6'h05 && !bus.branch_equal);
      e_stall = 0; e_flush = 0; mdu_stall = 0; n_hold = 0;
      if (m_hold)                                 e_stall = 1;
      else if (m_lock)                            begin e_stall = 1; mdu_stall = 1; end
      else if (m_rem > 0 && (is_md || is_mf))     begin e_stall = 1; mdu_stall = 1; end
      else if (bd && bus.ex_memread)              begin e_stall = 1; n_hold = 1; end
      else if (lu || bd)                          e_stall = 1;
      else if (taken)                             e_flush = 1;
      if (e_stall)      exp = STALL;
      else if (e_flush) exp = TAKEN;
      else              exp = NORM;
      if (m_rem > 0) exp = exp | BUSY;
      if (is_md && !e_stall) m_rem = MDU_LAT - 1;
      else if (m_rem > 0)    m_rem = m_rem - 1;
      m_lock = mdu_stall && (m_rem > 0);
      m_hold = n_hold;
    end
    cmp({tag, ".model"}, 16'(obs), 16'(exp));
    if (use_const) cmp({tag, ".const"}, 16'(obs), 16'(want));
`ifdef HAZARD_PERF_EN
    cmp({tag, ".stall_cnt"}, stall_cnt, 16'(m_stalls));
    cmp({tag, ".flush_cnt"}, flush_cnt, 16'(m_flushes));
    if (!rst) begin
      if (exp == STALL || exp == (STALL | BUSY)) m_stalls++;
      if (exp == TAKEN || exp == (TAKEN | BUSY)) m_flushes++;
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    drive(6'h00, 6'h20, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    step("reset", 1, RSTV);
    rst = 1'b0;

    // Load-use: one stall, then normal once EX holds the bubble.
    drive(6'h00, 6'h20, 5'd8, 5'd2, 1'b0, 1'b1, 1'b1, 5'd8);
    step("lu_stall", 1, STALL);
    drive(6'h00, 6'h20, 5'd8, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0);
    step("lu_release", 1, NORM);

    // Load-to-branch: two stall cycles, no flush.
    drive(6'h04, 6'h00, 5'd1, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9);
    step("lb_stall1", 1, STALL);
    drive(6'h04, 6'h00, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0);
    step("lb_stall2", 1, STALL);
    step("lb_release", 1, NORM);

    // Taken beq flushes; bne on equal operands falls through.
    drive(6'h04, 6'h00, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0);
    step("beq_taken", 1, TAKEN);
    drive(6'h05, 6'h00, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0);
    step("bne_not_taken", 1, NORM);

    // mult then mflo: three busy/stalled cycles.
    drive(6'h00, 6'h18, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0);
    step("mult_issue", 1, NORM);
    drive(6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    step("mflo_wait1", 1, STALL | BUSY);
    step("mflo_wait2", 1, STALL | BUSY);
    step("mflo_wait3", 1, STALL | BUSY);
    step("mflo_go", 1, NORM);

    // Load into $0 is never a hazard.
    drive(6'h00, 6'h20, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0);
    step("zero_reg", 1, NORM);

    // Reset in the middle of MDU_WAIT abandons the stall.
    drive(6'h00, 6'h1A, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0);
    step("div_issue", 1, NORM);
    drive(6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    step("mfhi_wait", 1, STALL | BUSY);
    rst = 1'b1;
    step("rst_mid_wait", 1, RSTV);
    rst = 1'b0;
    step("after_rst", 1, NORM);

    // Randomized traffic biased toward hazards.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 7))
        0, 1, 2: op = 6'h00;
        3:       op = 6'h04;
        4:       op = 6'h05;
        5:       op = 6'h23;
        6:       op = 6'h2B;
        default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       fn = 6'h18;
        1:       fn = 6'h1A;
        2:       fn = 6'h10;
        3:       fn = 6'h12;
        4:       fn = 6'h20;
        default: fn = 6'($urandom);
      endcase
      drive(op, fn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)));
      step("random", 0, 6'b0);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
